// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch stage. Owns the architectural PC and issues
//               one instruction-memory request at a time over a valid/ready
//               request channel with a valid-only response channel. Holds the
//               fetched word for the core and, when the core consumes it,
//               samples the branch comparator result to choose the next PC.
//               Misaligned taken targets redirect to TRAP_PC and raise a
//               one-cycle trap pulse. An external flush redirects the PC from
//               any state and discards any response still in flight.
//
// Ports       :
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts request this cycle
//   imem_addr       out  32  fetch address (word aligned)
//   imem_rsp_valid  in   1   response valid (one per accepted request)
//   imem_rsp_data   in   32  instruction word
//   instr_valid     out  1   instr_out / instr_pc valid for the core
//   instr_ready     in   1   core consumes the held instruction
//   instr_out       out  32  held instruction
//   instr_pc        out  32  PC of held instruction
//   branchTaken     in   1   comparator result, sampled only on consume
//   branch_target   in   32  branch/jump target, sampled only on consume
//   flush_valid     in   1   external redirect, highest priority
//   flush_pc        in   32  redirect address, low two bits ignored
//   misaligned_trap out  1   one-cycle pulse for a misaligned taken target
//   trap_addr       out  32  offending target, valid with misaligned_trap
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory request / response
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    // instruction hand-off to the core
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    // control-flow resolution from the branch comparator
    input  logic        branchTaken,
    input  logic [31:0] branch_target,
    // external redirect (trap / interrupt)
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    // misaligned-target trap report
    output logic        misaligned_trap,
    output logic [31:0] trap_addr
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle = 3'd0;  // one cycle after reset release
    localparam logic [2:0] c_st_req  = 3'd1;  // request presented to memory
    localparam logic [2:0] c_st_wait = 3'd2;  // request accepted, awaiting data
    localparam logic [2:0] c_st_hold = 3'd3;  // instruction held for the core
    localparam logic [2:0] c_st_drop = 3'd4;  // awaiting a response to discard

    localparam logic [31:0] c_pc_step = 32'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_trap;
    logic [31:0] r_trap_addr;

    // ------------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------------
    logic [2:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_capture;     // latch the response into the holding register
    logic        w_trap_nxt;    // raise the trap pulse next cycle
    logic        w_consume;     // core takes the instruction and no flush wins
    logic [31:0] w_flush_pc;    // flush address forced to word alignment
    logic [31:0] w_seq_pc;      // fall-through address of the held instruction
    logic        w_tgt_misalign;
    logic [31:0] w_resolved_pc; // next PC chosen from the branch outcome

    assign w_flush_pc     = flush_pc & ~32'd3;
    // 32-bit add wraps 0xFFFF_FFFC back to 0 by construction.
    assign w_seq_pc       = r_instr_pc + c_pc_step;
    assign w_tgt_misalign = (branch_target[1:0] != 2'b00);
    // A flush in the same cycle as a consume cancels the consume entirely, so
    // the branch inputs must not be looked at then.
    assign w_consume      = (r_state == c_st_hold) && instr_ready && !flush_valid;

    always_comb begin
        w_resolved_pc = w_seq_pc;
        if (branchTaken) begin
            w_resolved_pc = w_tgt_misalign ? TRAP_PC : branch_target;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_trap_nxt  = 1'b0;

        if (flush_valid) begin
            // Redirect always lands on the new PC; the only question is whether
            // a response is still owed by memory and must be swallowed first.
            w_pc_nxt = w_flush_pc;
            case (r_state)
                c_st_req: begin
                    // An accepted request cannot be recalled; its data is dropped.
                    w_state_nxt = imem_req_ready ? c_st_drop : c_st_req;
                end
                c_st_wait, c_st_drop: begin
                    w_state_nxt = imem_rsp_valid ? c_st_req : c_st_drop;
                end
                default: begin
                    // IDLE, HOLD and any unused encoding: nothing outstanding.
                    w_state_nxt = c_st_req;
                end
            endcase
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_state_nxt = c_st_req;
                end
                c_st_req: begin
                    if (imem_req_ready) begin
                        w_state_nxt = c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (imem_rsp_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (w_consume) begin
                        w_pc_nxt    = w_resolved_pc;
                        w_trap_nxt  = branchTaken && w_tgt_misalign;
                        w_state_nxt = c_st_req;
                    end
                end
                c_st_drop: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = c_st_req;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_instr_pc  <= RESET_PC;
            r_trap      <= 1'b0;
            r_trap_addr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_trap  <= w_trap_nxt;
            if (w_capture) begin
                r_instr    <= imem_rsp_data;
                // The PC register still holds the address that was fetched.
                r_instr_pc <= r_pc;
            end
            if (w_trap_nxt) begin
                r_trap_addr <= branch_target;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req_valid  = (r_state == c_st_req);
    assign imem_addr       = r_pc;
    assign instr_valid     = (r_state == c_st_hold);
    assign instr_out       = r_instr;
    assign instr_pc        = r_instr_pc;
    assign misaligned_trap = r_trap;
    assign trap_addr       = r_trap_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. A transaction-level
//               reference model (next fetch address, outstanding request,
//               held instruction) predicts every cycle's outputs; directed
//               scenarios cover reset, sequential fetch, branches, traps,
//               flushes and PC wrap, followed by randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        branchTaken;
    logic [31:0] branch_target;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        misaligned_trap;
    logic [31:0] trap_addr;

    fetch_pc_unit #(
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .branchTaken     (branchTaken),
        .branch_target   (branch_target),
        .flush_valid     (flush_valid),
        .flush_pc        (flush_pc),
        .misaligned_trap (misaligned_trap),
        .trap_addr       (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (transaction level) ------------------
    bit          m_idle;    // first cycle after reset release
    bit          m_out;     // a request was accepted and its response is owed
    bit          m_stale;   // the owed response must be thrown away
    bit          m_held;    // an instruction is waiting for the core
    bit          m_trap;
    bit          m_fired;   // request accepted in the last modelled cycle
    logic [31:0] m_pc;      // address of the next fetch
    logic [31:0] m_raddr;   // address of the outstanding request
    logic [31:0] m_iout;
    logic [31:0] m_ipc;
    logic [31:0] m_taddr;
    int          m_dly;     // random memory latency countdown

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_out = 0; m_stale = 0; m_held = 0; m_trap = 0; m_fired = 0;
        m_pc = RESET_PC; m_raddr = RESET_PC; m_iout = 0; m_ipc = RESET_PC;
        m_taddr = 0; m_dly = 0;
    endtask

    task automatic check_outputs();
        bit e_req;
        e_req = !m_idle && !m_out && !m_held;
        check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
        if (e_req) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_held});
        if (m_held) begin
            check_eq("instr_out", instr_out, m_iout);
            check_eq("instr_pc", instr_pc, m_ipc);
        end
        check_eq("trap", {31'd0, misaligned_trap}, {31'd0, m_trap});
        if (m_trap) check_eq("trap_addr", trap_addr, m_taddr);
    endtask

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic cycle();
        bit e_req, fire, rsp;
        e_req = !m_idle && !m_out && !m_held;
        fire  = e_req && imem_req_ready;
        rsp   = m_out && imem_rsp_valid;
        m_trap  = 0;
        m_fired = fire;
        m_idle  = 0;
        if (flush_valid) begin
            m_pc   = flush_pc & 32'hFFFF_FFFC;
            m_held = 0;
            if (fire) begin
                m_out = 1; m_stale = 1;
            end else if (m_out && !imem_rsp_valid) begin
                m_stale = 1;
            end else begin
                m_out = 0;
            end
        end else if (fire) begin
            m_out = 1; m_stale = 0; m_raddr = m_pc;
        end else if (rsp) begin
            m_out = 0;
            if (!m_stale) begin
                m_held = 1; m_iout = imem_rsp_data; m_ipc = m_raddr;
            end
        end else if (m_held && instr_ready) begin
            m_held = 0;
            if (!branchTaken)                    m_pc = m_ipc + 32'd4;
            else if (branch_target % 4 == 0)     m_pc = branch_target;
            else begin
                m_pc = TRAP_PC; m_trap = 1; m_taddr = branch_target;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'hDEAD_BEEF;
        instr_ready = 0; branchTaken = 0; branch_target = 0;
        flush_valid = 0; flush_pc = 0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            cycle();
            n++;
        end
        if (!imem_req_valid) check_eq("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch_to_hold(input int rw, input int sw, input logic [31:0] data,
                                 output logic [31:0] a);
        idle_inputs();
        wait_req();
        a = imem_addr;
        repeat (rw) cycle();
        imem_req_ready = 1; cycle(); imem_req_ready = 0;
        repeat (sw) cycle();
        imem_rsp_valid = 1; imem_rsp_data = data; cycle(); imem_rsp_valid = 0;
        check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("hold_pc", instr_pc, a);
        check_eq("hold_data", instr_out, data);
    endtask

    task automatic consume(input logic bt, input logic [31:0] tgt);
        instr_ready = 1; branchTaken = bt; branch_target = tgt;
        cycle();
        instr_ready = 0; branchTaken = 0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        check_outputs();

        // T1: first request at RESET_PC, then reset asserted mid-WAIT
        cycle();
        check_eq("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("t1_first_addr", imem_addr, RESET_PC);
        imem_req_ready = 1; cycle(); imem_req_ready = 0;
        #2 rst_n = 0;
        #1;
        check_eq("t1_rst_req", {31'd0, imem_req_valid}, 32'd0);
        check_eq("t1_rst_ivalid", {31'd0, instr_valid}, 32'd0);
        check_eq("t1_rst_instr", instr_out, 32'd0);
        check_eq("t1_rst_ipc", instr_pc, RESET_PC);
        check_eq("t1_rst_trap", {31'd0, misaligned_trap}, 32'd0);
        check_eq("t1_rst_taddr", trap_addr, 32'd0);
        check_eq("t1_rst_addr", imem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        check_outputs();

        // T2: sequential fetch with and without stalls
        fetch_to_hold(0, 0, 32'h1111_0001, a); check_eq("t2_addr0", a, 32'h0);
        consume(0, 32'h0);
        fetch_to_hold(2, 2, 32'h2222_0002, a); check_eq("t2_addr1", a, 32'h4);
        consume(0, 32'h0);
        fetch_to_hold(0, 2, 32'h3333_0003, a); check_eq("t2_addr2", a, 32'h8);

        // T3: aligned taken branch
        consume(1, 32'h40);
        check_eq("t3_no_trap", {31'd0, misaligned_trap}, 32'd0);
        fetch_to_hold(1, 0, 32'h4444_0004, a); check_eq("t3_addr", a, 32'h40);

        // T4: misaligned taken target
        consume(1, 32'h42);
        check_eq("t4_trap", {31'd0, misaligned_trap}, 32'd1);
        check_eq("t4_trap_addr", trap_addr, 32'h42);
        cycle();
        check_eq("t4_trap_pulse", {31'd0, misaligned_trap}, 32'd0);
        fetch_to_hold(0, 0, 32'h5555_0005, a); check_eq("t4_addr", a, TRAP_PC);
        consume(0, 32'h0);

        // T5: flush while WAIT, response arrives two cycles later
        wait_req();
        imem_req_ready = 1; cycle(); imem_req_ready = 0;
        flush_valid = 1; flush_pc = 32'h200; cycle(); flush_valid = 0;
        cycle();
        imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_BAD0; cycle(); imem_rsp_valid = 0;
        check_eq("t5_ivalid", {31'd0, instr_valid}, 32'd0);
        check_eq("t5_req", {31'd0, imem_req_valid}, 32'd1);
        check_eq("t5_addr", imem_addr, 32'h200);

        // T6: flush and consume together in HOLD; then PC wrap
        fetch_to_hold(0, 0, 32'h6666_0006, a); check_eq("t6_addr", a, 32'h200);
        instr_ready = 1; branchTaken = 1; branch_target = 32'h42;
        flush_valid = 1; flush_pc = 32'h302;
        cycle();
        idle_inputs();
        check_eq("t6_no_trap", {31'd0, misaligned_trap}, 32'd0);
        check_eq("t6_flush_addr", imem_addr, 32'h300);
        flush_valid = 1; flush_pc = 32'hFFFF_FFFF; cycle(); flush_valid = 0;
        fetch_to_hold(0, 1, 32'h7777_0007, a); check_eq("t6_top_addr", a, 32'hFFFF_FFFC);
        consume(0, 32'h0);
        check_eq("t6_wrap_addr", imem_addr, 32'h0);

        // Randomized traffic against the model
        m_dly = 0;
        for (int i = 0; i < 4000; i++) begin
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = m_out ? (m_dly == 0) : ($urandom_range(0, 7) == 0);
            imem_rsp_data  = $urandom;
            instr_ready    = $urandom_range(0, 1) == 1;
            branchTaken    = $urandom_range(0, 1) == 1;
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       branch_target = r;
                1:       branch_target = 32'hFFFF_FFFC;
                default: branch_target = r & 32'h0000_FFFC;
            endcase
            flush_valid = ($urandom_range(0, 15) == 0);
            flush_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            cycle();
            if (m_fired)                 m_dly = $urandom_range(0, 3);
            else if (m_out && m_dly > 0) m_dly--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
